// File: rtl/atomic_counter_arbiter_if.sv
// Read-port bundle between the requesters, the arbiter and the atomic counter.
// The arbiter connects through the master modport; the agents side uses slave.
interface atomic_counter_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] rd_req_i;
    logic [NUM_REQ-1:0] rd_gnt_o;
    logic [NUM_REQ-1:0] rd_valid_o;
    logic [63:0]        rd_data_o;
    logic               rd_err_o;
    logic               cnt_req_o;
    logic               cnt_atomic_o;
    logic               cnt_ack_i;
    logic [31:0]        cnt_count_i;

    modport master (
        input  rd_req_i,
        input  cnt_ack_i,
        input  cnt_count_i,
        output rd_gnt_o,
        output rd_valid_o,
        output rd_data_o,
        output rd_err_o,
        output cnt_req_o,
        output cnt_atomic_o
    );

    modport slave (
        output rd_req_i,
        output cnt_ack_i,
        output cnt_count_i,
        input  rd_gnt_o,
        input  rd_valid_o,
        input  rd_data_o,
        input  rd_err_o,
        input  cnt_req_o,
        input  cnt_atomic_o
    );
endinterface

// File: rtl/atomic_counter_arbiter.sv
// Round-robin arbiter giving coherent two-beat 64-bit counter snapshots.
// Optional ack watchdog is built when ACK_TIMEOUT_EN is defined.
module atomic_counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  reset_n,
    atomic_counter_arbiter_if.master bus
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LSB  = 2'd1;
    localparam logic [1:0] S_MSB  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("atomic_counter_arbiter: NUM_REQ must be 2..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("atomic_counter_arbiter: TIMEOUT must be >= 1");
    end

    logic [1:0]         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win;
    logic [31:0]        lsb_q;
    logic [31:0]        msb_q;
    logic               err_q;
    logic               tmo_hit;

    logic               pick_vld;
    logic [PW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick_oh;

    // First requester at or after the pointer, wrapping; lowest offset wins.
    always_comb begin
        int k;
        k        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (bus.rd_req_i[PW'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(k);
            end
        end
    end

    assign pick_oh = NUM_REQ'(1) << pick_idx;

`ifdef ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q;
    logic          beat_wait;

    assign beat_wait = (state == S_LSB) || (state == S_MSB);
    assign tmo_hit   = beat_wait && !bus.cnt_ack_i &&
                       (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (beat_wait && !bus.cnt_ack_i && !tmo_hit) begin
            tmo_q <= tmo_q + TW'(1);
        end else begin
            tmo_q <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            ptr              <= '0;
            win              <= '0;
            lsb_q            <= '0;
            msb_q            <= '0;
            err_q            <= 1'b0;
            bus.rd_gnt_o     <= '0;
            bus.rd_valid_o   <= '0;
            bus.rd_data_o    <= '0;
            bus.rd_err_o     <= 1'b0;
            bus.cnt_req_o    <= 1'b0;
            bus.cnt_atomic_o <= 1'b0;
        end else begin
            bus.rd_valid_o <= '0;
            bus.rd_err_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        win              <= pick_idx;
                        bus.rd_gnt_o     <= pick_oh;
                        bus.cnt_req_o    <= 1'b1;
                        bus.cnt_atomic_o <= 1'b1;
                        err_q            <= 1'b0;
                        state            <= S_LSB;
                    end
                end
                S_LSB: begin
                    if (tmo_hit) begin
                        bus.cnt_req_o    <= 1'b0;
                        bus.cnt_atomic_o <= 1'b0;
                        err_q            <= 1'b1;
                        state            <= S_RESP;
                    end else if (bus.cnt_ack_i) begin
                        lsb_q            <= bus.cnt_count_i;
                        bus.cnt_atomic_o <= 1'b0;
                        state            <= S_MSB;
                    end
                end
                S_MSB: begin
                    if (tmo_hit) begin
                        bus.cnt_req_o <= 1'b0;
                        err_q         <= 1'b1;
                        state         <= S_RESP;
                    end else if (bus.cnt_ack_i) begin
                        msb_q         <= bus.cnt_count_i;
                        bus.cnt_req_o <= 1'b0;
                        state         <= S_RESP;
                    end
                end
                default: begin
                    // Pulse the winner and move it to the back of the ring.
                    bus.rd_valid_o <= bus.rd_gnt_o;
                    bus.rd_data_o  <= err_q ? 64'd0 : {msb_q, lsb_q};
                    bus.rd_err_o   <= err_q;
                    bus.rd_gnt_o   <= '0;
                    err_q          <= 1'b0;
                    ptr            <= (win == PW'(NUM_REQ - 1)) ?
                                      '0 : win + PW'(1);
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/atomic_counter_arbiter.md
Name: atomic_counter_arbiter

Overview:
Shares one atomic 64-bit event counter read port (32-bit data, two-beat LSB-then-MSB access) among NUM_REQ requesters. Round-robin arbitration; the grant is locked across both beats so every requester receives a coherent 64-bit snapshot. Sits between the software/CSR read agents and the atomic counter block, and fully sequences the counter's req/atomic handshake.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
TIMEOUT, 16, ack watchdog limit in cycles (used only with ACK_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
rd_req_i  in  NUM_REQ  per-requester read request, level, held until rd_valid_o
rd_gnt_o  out  NUM_REQ  one-hot grant, high from grant through response cycle
rd_valid_o  out  NUM_REQ  one-cycle pulse to the served requester
rd_data_o  out  64  snapshot {MSB,LSB}, valid when any rd_valid_o bit is high
rd_err_o  out  1  timeout error flag, qualified by rd_valid_o (ACK_TIMEOUT_EN only, else tied 0)
cnt_req_o  out  1  request to counter
cnt_atomic_o  out  1  snapshot strobe, high on LSB beat only
cnt_ack_i  in  1  counter beat acknowledge
cnt_count_i  in  32  counter read data, sampled when cnt_ack_i=1

Behaviour:
- All outputs registered. Reset (async assert, sync deassert by the system): state IDLE, rd_gnt_o=0, rd_valid_o=0, rd_data_o=0, rd_err_o=0, cnt_req_o=0, cnt_atomic_o=0, RR pointer so requester 0 has highest priority.
- FSM IDLE -> LSB -> MSB -> RESP -> IDLE.
- IDLE: if any rd_req_i bit is set, pick the first set bit at or after the pointer (wrapping); next cycle: rd_gnt_o=one-hot winner, cnt_req_o=1, cnt_atomic_o=1, state LSB.
- LSB: hold cnt_req_o=1, cnt_atomic_o=1 until cnt_ack_i=1; on ack, latch cnt_count_i into data[31:0], drop cnt_atomic_o, keep cnt_req_o=1, go MSB.
- MSB: hold cnt_req_o=1, cnt_atomic_o=0 until cnt_ack_i=1; on ack, latch cnt_count_i into data[63:32], cnt_req_o=0, go RESP.
- RESP: rd_valid_o[winner]=1 for exactly one cycle, rd_data_o holds the snapshot (and keeps it until the next RESP); pointer = winner+1 mod NUM_REQ; rd_gnt_o clears; go IDLE.
- Minimum latency: grant to valid = 3 cycles with zero-wait ack; one read per 4 cycles at most.
- Once granted, the sequence completes even if the winner drops rd_req_i; the response is still pulsed. Requests dropped before grant are not served.
- cnt_ack_i while in IDLE or RESP is ignored.
- Simultaneous requests: strict RR; a requester holding rd_req_i waits at most NUM_REQ-1 transactions.
- Requester re-asserting in the RESP cycle is eligible in the next IDLE but ranked after all others.
- Reset mid-transaction aborts immediately; no rd_valid_o is emitted for the aborted read.

Optional Feature:
ACK_TIMEOUT_EN: when defined, a counter runs in LSB/MSB and resets on each ack; reaching TIMEOUT cycles without ack forces cnt_req_o=0, cnt_atomic_o=0, and goes to RESP with rd_err_o=1 and rd_data_o=0. When undefined, no counter is built, the FSM waits indefinitely for ack, and rd_err_o is constant 0.

Test Plan:
- Single read, model value 64'h0000_0001_0000_0005, zero-wait ack, rd_req_i=4'b0001 -> rd_gnt_o=0001, atomic high only on beat 1, rd_valid_o=0001 three cycles after grant, rd_data_o=64'h0000_0001_0000_0005.
- All four requesters held high from reset -> service order 0,1,2,3,0; each rd_valid_o pulse one cycle, 4 cycles apart.
- Model at 64'h0000_0000_FFFF_FFFF, model increments between LSB and MSB beats -> rd_data_o=64'h0000_0000_FFFF_FFFF (atomic snapshot, no tear).
- Ack delayed 3 cycles per beat -> cnt_req_o/cnt_atomic_o held stable through stalls; valid 9 cycles after grant; requester 2 dropping rd_req_i mid-read still gets rd_valid_o[2].
- Assert reset_n=0 during MSB -> all outputs 0 the same cycle, no valid pulse; next request from requester 3 is preceded by requester 0 if both pending.
- ACK_TIMEOUT_EN, TIMEOUT=16, ack never returned -> after 16 cycles in LSB, rd_valid_o pulses with rd_err_o=1, rd_data_o=0, cnt_req_o=0.
